// File: rtl/vic_irq_sequencer_if.sv
// vic_irq_sequencer_if
//   Bundles the CPU handshake, interrupt sources and software config port of
//   vic_irq_sequencer.
//   master : source/CPU/software side (drives i_*, observes o_*)
//   slave  : the sequencer (observes i_*, drives o_*)
//   i_irq_src[16]  vectored sources, rising-edge events
//   i_nv_irq       non-vectored source, level-sensitive
//   i_irq_ack      CPU accepts current request
//   i_irq_eoi      CPU finished handler (1-cycle pulse)
//   i_cfg_we/i_cfg_addr[2]/i_cfg_wdata[16]  config write port
//   o_cfg_rdata[16] registered read data
//   o_irq_req, o_irq_num[4], o_irq_is_nv, o_in_service  CPU-facing status
interface vic_irq_sequencer_if;
    logic [15:0] i_irq_src;
    logic        i_nv_irq;
    logic        i_irq_ack;
    logic        i_irq_eoi;
    logic        i_cfg_we;
    logic [1:0]  i_cfg_addr;
    logic [15:0] i_cfg_wdata;
    logic [15:0] o_cfg_rdata;
    logic        o_irq_req;
    logic [3:0]  o_irq_num;
    logic        o_irq_is_nv;
    logic        o_in_service;

    modport master (
        output i_irq_src, i_nv_irq, i_irq_ack, i_irq_eoi,
               i_cfg_we, i_cfg_addr, i_cfg_wdata,
        input  o_cfg_rdata, o_irq_req, o_irq_num, o_irq_is_nv, o_in_service
    );

    modport slave (
        input  i_irq_src, i_nv_irq, i_irq_ack, i_irq_eoi,
               i_cfg_we, i_cfg_addr, i_cfg_wdata,
        output o_cfg_rdata, o_irq_req, o_irq_num, o_irq_is_nv, o_in_service
    );
endinterface

// File: rtl/vic_irq_sequencer.sv
// vic_irq_sequencer
//   Latches rising edges on 16 vectored sources, masks them with ENABLE and
//   delivers one interrupt at a time to the CPU through a req/ack/EOI
//   handshake. A level-sensitive non-vectored source is served only when no
//   vectored source is eligible.
//   Ports: clk, rst (async, active high), bus (vic_irq_sequencer_if.slave).
//   Config map: 0 ENABLE, 1 PENDING (W1C), 2 SWTRIG (W1S), 3 STATUS
//   (read {state, 9'b0, is_nv, num}; write bit 0 = nv_en).
//   Optional macro VIC_ROUND_ROBIN_EN: rotating vectored priority pointer.
module vic_irq_sequencer #(
    parameter int HOLDOFF   = 2,
    parameter int HOLDOFF_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vic_irq_sequencer_if.slave   bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;
    localparam logic [1:0] S_HOLDOFF = 2'd3;
    localparam logic [HOLDOFF_W-1:0] HO_LAST = HOLDOFF_W'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);

    logic [1:0]           r_state;
    logic [15:0]          r_enable;
    logic [15:0]          r_pending;
    logic [15:0]          r_prev_src;
    logic                 r_nv_en;
    logic [3:0]           r_num;
    logic                 r_is_nv;
    logic [HOLDOFF_W-1:0] r_hcnt;
    logic [15:0]          r_rdata;

    logic [15:0] w_elig;
    logic        w_vec_any;
    logic        w_nv_elig;
    logic [3:0]  w_win;
    logic        w_still;
    logic        w_ack;
    logic [15:0] w_set;
    logic [15:0] w_clr;

    assign w_elig    = r_pending & r_enable;
    assign w_vec_any = |w_elig;
    assign w_nv_elig = bus.i_nv_irq & r_nv_en & ~w_vec_any;
    // The latched winner is not re-arbitrated; it only has to stay eligible itself.
    assign w_still   = r_is_nv ? (bus.i_nv_irq & r_nv_en) : w_elig[r_num];
    assign w_ack     = (r_state == S_REQ) && bus.i_irq_ack;

`ifdef VIC_ROUND_ROBIN_EN
    logic [3:0] r_ptr;
    logic [3:0] w_idx;

    // Descending scan: the last hit is the one closest above the pointer.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = 15; k >= 0; k--) begin
            w_idx = r_ptr + 4'(k);
            if (w_elig[w_idx]) w_win = w_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_ptr <= '0;
        else if (w_ack && !r_is_nv) r_ptr <= r_num + 4'd1;
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = 15; k >= 0; k--)
            if (w_elig[k]) w_win = 4'(k);
    end
`endif

    // Set beats clear when both hit the same bit in one cycle.
    assign w_set = (bus.i_irq_src & ~r_prev_src)
                 | ((bus.i_cfg_we && bus.i_cfg_addr == 2'd2) ? bus.i_cfg_wdata : 16'h0);
    assign w_clr = ((bus.i_cfg_we && bus.i_cfg_addr == 2'd1) ? bus.i_cfg_wdata : 16'h0)
                 | ((w_ack && !r_is_nv) ? (16'h1 << r_num) : 16'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_src <= '0;
            r_pending  <= '0;
            r_enable   <= '0;
            r_nv_en    <= 1'b0;
        end else begin
            r_prev_src <= bus.i_irq_src;
            r_pending  <= (r_pending & ~w_clr) | w_set;
            if (bus.i_cfg_we && bus.i_cfg_addr == 2'd0) r_enable <= bus.i_cfg_wdata;
            if (bus.i_cfg_we && bus.i_cfg_addr == 2'd3) r_nv_en  <= bus.i_cfg_wdata[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_is_nv <= 1'b0;
            r_hcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_vec_any) begin
                        r_num   <= w_win;
                        r_is_nv <= 1'b0;
                        r_state <= S_REQ;
                    end else if (w_nv_elig) begin
                        r_num   <= '0;
                        r_is_nv <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.i_irq_ack)  r_state <= S_SERVICE;
                    else if (!w_still)  r_state <= S_IDLE;
                end
                S_SERVICE: begin
                    if (bus.i_irq_eoi) begin
                        r_hcnt  <= '0;
                        r_state <= (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                    end
                end
                default: begin
                    if (r_hcnt == HO_LAST) begin
                        r_hcnt  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_hcnt  <= r_hcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            case (bus.i_cfg_addr)
                2'd0:    r_rdata <= r_enable;
                2'd1:    r_rdata <= r_pending;
                2'd2:    r_rdata <= 16'h0;
                default: r_rdata <= {r_state, 9'b0, r_is_nv, r_num};
            endcase
        end
    end

    assign bus.o_cfg_rdata  = r_rdata;
    assign bus.o_irq_req    = (r_state == S_REQ);
    assign bus.o_in_service = (r_state == S_SERVICE);
    assign bus.o_irq_num    = r_num;
    assign bus.o_irq_is_nv  = r_is_nv;
endmodule

// File: tb/tb_vic_irq_sequencer.sv
module tb_vic_irq_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct packed {
        logic       nv;
        logic [3:0] num;
    } exp_t;

    exp_t exp_q[$];
    logic prev_req;

    vic_irq_sequencer_if bus();

    vic_irq_sequencer #(.HOLDOFF(2), .HOLDOFF_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [15:0] d);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = a;
        bus.i_cfg_wdata = d;
        tick();
        bus.i_cfg_we    = 1'b0;
    endtask

    task automatic cfg_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        bus.i_cfg_addr = a;
        tick();
        chk(tag, 32'(bus.o_cfg_rdata), 32'(exp));
    endtask

    task automatic pulse_src(input logic [15:0] m);
        bus.i_irq_src = m;
        tick();
        bus.i_irq_src = '0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        for (int i = 0; i < budget && !bus.o_irq_req; i++) tick();
        chk(tag, 32'(bus.o_irq_req), 32'd1);
    endtask

    task automatic do_ack();
        bus.i_irq_ack = 1'b1;
        tick();
        bus.i_irq_ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.i_irq_eoi = 1'b1;
        tick();
        bus.i_irq_eoi = 1'b0;
    endtask

    task automatic push(input logic nv, input logic [3:0] n);
        exp_t e;
        e.nv  = nv;
        e.num = n;
        exp_q.push_back(e);
    endtask

    // Scoreboard: each new request is compared with the oldest expectation.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            prev_req <= bus.o_irq_req;
            if (bus.o_irq_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("sb_is_nv", 32'(bus.o_irq_is_nv), 32'(exp_q[0].nv));
                    if (!exp_q[0].nv) chk("sb_num", 32'(bus.o_irq_num), 32'(exp_q[0].num));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.i_irq_src   = '0;
        bus.i_nv_irq    = 1'b0;
        bus.i_irq_ack   = 1'b0;
        bus.i_irq_eoi   = 1'b0;
        bus.i_cfg_we    = 1'b0;
        bus.i_cfg_addr  = '0;
        bus.i_cfg_wdata = '0;
        repeat (2) tick();
        chk("rst_req", 32'(bus.o_irq_req), 0);
        chk("rst_insvc", 32'(bus.o_in_service), 0);
        chk("rst_num", 32'(bus.o_irq_num), 0);
        chk("rst_nv", 32'(bus.o_irq_is_nv), 0);
        chk("rst_rdata", 32'(bus.o_cfg_rdata), 0);
        rst = 1'b0;
        tick();

        // single vector: latency, ack clears pending, holdoff timing
        cfg_wr(2'd0, 16'h0001);
        push(1'b0, 4'd0);
        pulse_src(16'h0001);
        chk("t1_lat_k", 32'(bus.o_irq_req), 0);
        tick();
        chk("t1_lat_k1", 32'(bus.o_irq_req), 1);
        chk("t1_num", 32'(bus.o_irq_num), 0);
        cfg_rd("t1_pend_set", 2'd1, 16'h0001);
        do_ack();
        chk("t1_insvc", 32'(bus.o_in_service), 1);
        chk("t1_req_drop", 32'(bus.o_irq_req), 0);
        cfg_rd("t1_pend_clr", 2'd1, 16'h0000);
        do_eoi();
        chk("t1_eoi_insvc", 32'(bus.o_in_service), 0);
        cfg_rd("t1_holdoff", 2'd3, 16'hC000);
        tick();
        cfg_rd("t1_idle", 2'd3, 16'h0000);

        // two simultaneous vectors: lower index first
        cfg_wr(2'd0, 16'hFFFF);
        push(1'b0, 4'd3);
        push(1'b0, 4'd9);
        pulse_src(16'h0208);
        wait_req("t2_req3", 5);
        do_ack();
        do_eoi();
        wait_req("t2_req9", 10);
        do_ack();
        do_eoi();
        repeat (3) tick();
        cfg_rd("t2_pend_empty", 2'd1, 16'h0000);

        // non-vectored request, withdrawn when the level drops
        cfg_wr(2'd3, 16'h0001);
        push(1'b1, 4'd0);
        bus.i_nv_irq = 1'b1;
        wait_req("t3_nv_req", 5);
        chk("t3_is_nv", 32'(bus.o_irq_is_nv), 1);
        bus.i_nv_irq = 1'b0;
        tick();
        chk("t3_withdraw", 32'(bus.o_irq_req), 0);
        cfg_rd("t3_status", 2'd3, 16'h0010);
        cfg_wr(2'd3, 16'h0000);

        // W1C withdraws; no re-arbitration; W1C + ack together -> service
        push(1'b0, 4'd5);
        cfg_wr(2'd2, 16'h0020);
        wait_req("t4_req5", 5);
        cfg_wr(2'd1, 16'h0020);
        chk("t4_still_req", 32'(bus.o_irq_req), 1);
        tick();
        chk("t4_withdrawn", 32'(bus.o_irq_req), 0);
        cfg_rd("t4_pend", 2'd1, 16'h0000);
        push(1'b0, 4'd5);
        cfg_wr(2'd2, 16'h0020);
        wait_req("t4_req5b", 5);
        push(1'b0, 4'd1);
        cfg_wr(2'd2, 16'h0002);
        chk("t4_no_rearb", 32'(bus.o_irq_num), 5);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = 2'd1;
        bus.i_cfg_wdata = 16'h0020;
        bus.i_irq_ack   = 1'b1;
        tick();
        bus.i_cfg_we    = 1'b0;
        bus.i_irq_ack   = 1'b0;
        chk("t4_ack_wins", 32'(bus.o_in_service), 1);
        do_eoi();
        wait_req("t4_req1", 10);
        do_ack();
        do_eoi();
        repeat (3) tick();

        // re-edge during service, and set-beats-ack-clear
        push(1'b0, 4'd2);
        pulse_src(16'h0004);
        wait_req("t5_req2", 5);
        do_ack();
        push(1'b0, 4'd2);
        pulse_src(16'h0004);
        cfg_rd("t5_repend", 2'd1, 16'h0004);
        do_eoi();
        wait_req("t5_redeliver", 10);
        push(1'b0, 4'd2);
        bus.i_cfg_we    = 1'b1;
        bus.i_cfg_addr  = 2'd2;
        bus.i_cfg_wdata = 16'h0004;
        bus.i_irq_ack   = 1'b1;
        tick();
        bus.i_cfg_we    = 1'b0;
        bus.i_irq_ack   = 1'b0;
        cfg_rd("t5_set_wins", 2'd1, 16'h0004);
        do_eoi();
        wait_req("t5_req2c", 10);
        do_ack();
        do_eoi();
        repeat (3) tick();

        // async reset during service
        push(1'b0, 4'd7);
        pulse_src(16'h0080);
        wait_req("t6_req7", 5);
        do_ack();
        cfg_wr(2'd2, 16'h0100);
        chk("t6_insvc", 32'(bus.o_in_service), 1);
        #3 rst = 1'b1;
        #1;
        chk("t6_rst_insvc", 32'(bus.o_in_service), 0);
        chk("t6_rst_req", 32'(bus.o_irq_req), 0);
        bus.i_irq_eoi = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.i_irq_eoi = 1'b0;
        chk("t6_eoi_ign", 32'(bus.o_in_service), 0);
        cfg_rd("t6_pend", 2'd1, 16'h0000);
        cfg_rd("t6_status", 2'd3, 16'h0000);
        cfg_rd("t6_enable", 2'd0, 16'h0000);
        chk("t6_req_idle", 32'(bus.o_irq_req), 0);

        chk("sb_left", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
